// File: rtl/mac_dot_seq_if.sv
// Job command, beat stream and result handshake for the dot-product sequencer.
interface mac_dot_seq_if #(
    parameter int unsigned a_bw    = 2,
    parameter int unsigned b_bw    = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned len_bw  = 8
);
    logic                start;
    logic [len_bw-1:0]   len;
    logic [psum_bw-1:0]  psum_init;
    logic                abort;
    logic                in_valid;
    logic                in_ready;
    logic [a_bw-1:0]     in_a;
    logic [b_bw-1:0]     in_b;
    logic                out_valid;
    logic                out_ready;
    logic [psum_bw-1:0]  out_psum;
    logic                busy;
    logic [len_bw-1:0]   beat_cnt;

    modport master (
        output start, len, psum_init, abort, in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_psum, busy, beat_cnt
    );

    modport slave (
        input  start, len, psum_init, abort, in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_psum, busy, beat_cnt
    );
endinterface

// File: rtl/mac_dot_seq.sv
// Sequences one dot-product job through a single MAC: unsigned activation x
// signed weight accumulated into a wrapping signed psum.
module mac_dot_seq #(
    parameter int unsigned a_bw    = 2,
    parameter int unsigned b_bw    = 4,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned len_bw  = 8
) (
    input  logic          clk,
    input  logic          reset,
    mac_dot_seq_if.slave  bus
);
    localparam int unsigned prod_w = a_bw + b_bw + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic signed [psum_bw-1:0]  acc, acc_nxt;
    logic [len_bw-1:0]          cnt, cnt_nxt;
    logic [len_bw-1:0]          len_q, len_nxt;
    logic signed [prod_w-1:0]   a_ext, b_ext, prod;

    // Next-state, accumulator and counter logic
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        len_nxt   = len_q;
        a_ext     = prod_w'($signed({1'b0, bus.in_a}));
        b_ext     = prod_w'($signed(bus.in_b));
        prod      = a_ext * b_ext;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt   = $signed(bus.psum_init);
                    cnt_nxt   = '0;
                    len_nxt   = bus.len;
                    state_nxt = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                // abort wins over a beat arriving in the same cycle
                if (bus.abort) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (bus.in_valid && bus.in_ready) begin
                    acc_nxt = acc + psum_bw'(prod);
                    cnt_nxt = cnt + len_bw'(1);
                    if (cnt == len_q - len_bw'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_valid && bus.out_ready) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs, the latter derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            len_q         <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_psum  <= '0;
            bus.busy      <= 1'b0;
            bus.beat_cnt  <= '0;
        end else begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            cnt           <= cnt_nxt;
            len_q         <= len_nxt;
            bus.in_ready  <= (state_nxt == ACCUM);
            bus.out_valid <= (state_nxt == DONE);
            bus.out_psum  <= (state_nxt == DONE) ? acc_nxt : '0;
            bus.busy      <= (state_nxt != IDLE);
            bus.beat_cnt  <= (state_nxt == IDLE) ? '0 : cnt_nxt;
        end
    end
endmodule
